// File: rtl/arb_rr_merge.sv
// Round-robin N:1 packet merge with one registered output stage (1-cycle latency).
// Backpressure: upstream Ack is raised only while the output register can load (empty or draining).
module arb_rr_merge #(
  parameter int N  = 2,
  parameter int W  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic           CLK,
  input  logic           MR,
  input  logic [N-1:0]   ARB_Send_in,
  input  logic [N-1:0]   ARB_Last_in,
  input  logic [N*W-1:0] ARB_Data_in,
  output logic [N-1:0]   ARB_Ack_in,
  output logic           ARB_Send_out,
  output logic           ARB_Last_out,
  output logic [W-1:0]   ARB_Data_out,
  output logic [SW-1:0]  ARB_Src_out,
  input  logic           ARB_Ack_out,
  output logic           ARB_Busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] gnt;

  logic          ov;
  logic          last_q;
  logic [W-1:0]  data_q;
  logic [SW-1:0] src_q;

  logic          can_load;
  logic          found;
  logic          any_req;
  logic          xfer;
  logic [SW-1:0] winner;
  logic [SW-1:0] sel;
  logic [SW-1:0] sel_next;
  logic          sel_send;
  logic          sel_last;
  logic [W-1:0]  sel_data;

  assign can_load = !ov || ARB_Ack_out;

  // Search order ptr, ptr+1, ... mod N; the lowest offset with Send wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && ARB_Send_in[i] && (i == ((int'(ptr) + k) % N))) begin
          found  = 1'b1;
          winner = SW'(i);
        end
      end
    end
  end

  assign sel      = (state == LOCKED) ? gnt : winner;
  assign any_req  = (state == LOCKED) || found;
  assign sel_next = (sel == SW'(N - 1)) ? '0 : sel + SW'(1);

  always_comb begin
    sel_send = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == sel) begin
        sel_send = ARB_Send_in[i];
        sel_last = ARB_Last_in[i];
        sel_data = ARB_Data_in[i*W +: W];
      end
    end
  end

  // In LOCKED the grant holder keeps its Ack even while it has dropped Send.
  always_comb begin
    ARB_Ack_in = '0;
    for (int i = 0; i < N; i++) begin
      ARB_Ack_in[i] = !MR && any_req && can_load && (SW'(i) == sel);
    end
  end

  assign xfer = !MR && any_req && can_load && sel_send;

  always_ff @(posedge CLK) begin
    if (MR) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      ov     <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      src_q  <= '0;
    end else begin
      if (xfer) begin
        ov     <= 1'b1;
        last_q <= sel_last;
        data_q <= sel_data;
        src_q  <= sel;
      end else if (ARB_Ack_out) begin
        ov <= 1'b0;
      end

      if (xfer) begin
        if (sel_last) begin
          state <= IDLE;
          ptr   <= sel_next;
        end else begin
          state <= LOCKED;
          gnt   <= sel;
        end
      end
    end
  end

  assign ARB_Send_out = ov;
  assign ARB_Last_out = last_q;
  assign ARB_Data_out = data_q;
  assign ARB_Src_out  = src_q;
  assign ARB_Busy     = (state == LOCKED) || ov;

  a_ack_onehot : assert property (@(posedge CLK) disable iff (MR) $onehot0(ARB_Ack_in));

  a_hold_stable : assert property (@(posedge CLK) disable iff (MR)
    (ARB_Send_out && !ARB_Ack_out) |=>
      (ARB_Send_out && $stable(ARB_Data_out) && $stable(ARB_Last_out) && $stable(ARB_Src_out)));

  a_ptr_range : assert property (@(posedge CLK) disable iff (MR) (int'(ptr) < N));

endmodule

// File: tb/tb_arb_rr_merge.sv
// Bench for arb_rr_merge (N=2): per-input source queues, output scoreboard, scenario tasks.
module tb_arb_rr_merge;

  localparam int N = 2;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           gap;
  } word_t;

  typedef struct {
    logic         src;
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic           clk;
  logic           mr;
  logic [N-1:0]   send_in;
  logic [N-1:0]   last_in;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   ack_in;
  logic           send_out;
  logic           last_out;
  logic [W-1:0]   data_out;
  logic [0:0]     src_out;
  logic           ack_out;
  logic           busy;

  word_t q0[$];
  word_t q1[$];
  exp_t  expq[$];
  int    gap_left[N];
  logic [N-1:0] took;
  int    checks;
  int    failures;

  arb_rr_merge #(.N(N), .W(W)) dut (
    .CLK          (clk),
    .MR           (mr),
    .ARB_Send_in  (send_in),
    .ARB_Last_in  (last_in),
    .ARB_Data_in  (data_in),
    .ARB_Ack_in   (ack_in),
    .ARB_Send_out (send_out),
    .ARB_Last_out (last_out),
    .ARB_Data_out (data_out),
    .ARB_Src_out  (src_out),
    .ARB_Ack_out  (ack_out),
    .ARB_Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream sources: pop on an accepted word, honour per-word idle gaps.
  always @(posedge clk) begin
    #2;
    if (took[0]) begin
      q0.delete(0);
      if (q0.size() > 0) gap_left[0] = q0[0].gap;
    end else if (gap_left[0] > 0 && q0.size() > 0) begin
      gap_left[0]--;
    end
    if (took[1]) begin
      q1.delete(0);
      if (q1.size() > 0) gap_left[1] = q1[0].gap;
    end else if (gap_left[1] > 0 && q1.size() > 0) begin
      gap_left[1]--;
    end
    send_in[0] = (q0.size() > 0) && (gap_left[0] == 0);
    send_in[1] = (q1.size() > 0) && (gap_left[1] == 0);
    last_in[0] = (q0.size() > 0) ? q0[0].last : 1'b0;
    last_in[1] = (q1.size() > 0) ? q1[0].last : 1'b0;
    data_in[0*W +: W] = (q0.size() > 0) ? q0[0].data : '0;
    data_in[1*W +: W] = (q1.size() > 0) ? q1[0].data : '0;
  end

  // Sample handshakes mid-cycle and score every downstream transfer.
  always @(negedge clk) begin
    exp_t e;
    took <= send_in & ack_in;
    if (send_out && ack_out && !mr) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected got src=%0d data=%h last=%0d, expected no word", src_out, data_out, last_out);
      end else begin
        e = expq.pop_front();
        if ({src_out, data_out, last_out} !== {e.src, e.data, e.last}) begin
          failures++;
          $display("FAIL out_word got src=%0d data=%h last=%0d, expected src=%0d data=%h last=%0d",
                   src_out, data_out, last_out, e.src, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input int i, input logic [W-1:0] d, input logic l, input int g);
    word_t w;
    w.data = d;
    w.last = l;
    w.gap  = g;
    if (i == 0) begin
      if (q0.size() == 0) gap_left[0] = g;
      q0.push_back(w);
    end else begin
      if (q1.size() == 0) gap_left[1] = g;
      q1.push_back(w);
    end
  endtask

  task automatic expect_out(input logic s, input logic [W-1:0] d, input logic l);
    exp_t e;
    e.src  = s;
    e.data = d;
    e.last = l;
    expq.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && expq.size() == 0 && !busy && !send_out) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain pending exp=%0d q0=%0d q1=%0d busy=%0d, expected all drained",
               name, expq.size(), q0.size(), q1.size(), busy);
    end
  endtask

  task automatic test_reset();
    cyc();
    push_in(0, 32'hA0, 1'b1, 0);
    push_in(1, 32'hB0, 1'b1, 0);
    expect_out(1'b0, 32'hA0, 1'b1);
    expect_out(1'b1, 32'hB0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      checks++; if (ack_in !== 2'b00) begin failures++; $display("FAIL rst_ack got %b expected 00", ack_in); end
      checks++; if (send_out !== 1'b0) begin failures++; $display("FAIL rst_send_out got %b expected 0", send_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b expected 0", busy); end
      checks++; if ({src_out, last_out, data_out} !== '0) begin
        failures++; $display("FAIL rst_outputs got src=%0d last=%0d data=%h expected zeros", src_out, last_out, data_out);
      end
    end
    cyc();
    mr = 1'b0;
    @(negedge clk);
    checks++; if (ack_in !== 2'b01) begin failures++; $display("FAIL rst_first_grant got %b expected 01", ack_in); end
    wait_idle("reset");
  endtask

  task automatic test_fair();
    cyc();
    for (int k = 0; k < 3; k++) begin
      push_in(0, 32'hA0 + k, 1'b1, 0);
      push_in(1, 32'hB0 + k, 1'b1, 0);
      expect_out(1'b0, 32'hA0 + k, 1'b1);
      expect_out(1'b1, 32'hB0 + k, 1'b1);
    end
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (send_out !== 1'b1) begin failures++; $display("FAIL fair_valid[%0d] got %b expected 1", k, send_out); end
      checks++; if (src_out !== 1'((k % 2))) begin failures++; $display("FAIL fair_src[%0d] got %0d expected %0d", k, src_out, k % 2); end
    end
    wait_idle("fair");
  endtask

  task automatic test_atomic();
    cyc();
    push_in(0, 32'hA0, 1'b0, 0);
    push_in(0, 32'hA1, 1'b1, 0);
    push_in(1, 32'hB0, 1'b1, 0);
    expect_out(1'b0, 32'hA0, 1'b0);
    expect_out(1'b0, 32'hA1, 1'b1);
    expect_out(1'b1, 32'hB0, 1'b1);
    @(negedge clk);
    checks++; if (ack_in !== 2'b01) begin failures++; $display("FAIL atom_first_ack got %b expected 01", ack_in); end
    @(negedge clk);
    checks++; if (ack_in !== 2'b01) begin failures++; $display("FAIL atom_locked_ack got %b expected 01", ack_in); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL atom_busy got %b expected 1", busy); end
    checks++; if (send_out !== 1'b1 || src_out !== 1'b0) begin failures++; $display("FAIL atom_w0 got vld=%b src=%0d expected vld=1 src=0", send_out, src_out); end
    @(negedge clk);
    checks++; if (send_out !== 1'b1 || src_out !== 1'b0) begin failures++; $display("FAIL atom_w1 got vld=%b src=%0d expected vld=1 src=0", send_out, src_out); end
    @(negedge clk);
    checks++; if (send_out !== 1'b1 || src_out !== 1'b1) begin failures++; $display("FAIL atom_w2 got vld=%b src=%0d expected vld=1 src=1", send_out, src_out); end
    wait_idle("atomic");
  endtask

  task automatic test_backpressure();
    cyc();
    ack_out = 1'b0;
    push_in(0, 32'h1234, 1'b1, 0);
    push_in(1, 32'h5678, 1'b1, 0);
    expect_out(1'b0, 32'h1234, 1'b1);
    expect_out(1'b1, 32'h5678, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (data_out !== 32'h1234) begin failures++; $display("FAIL bp_data[%0d] got %h expected 00001234", k, data_out); end
      checks++; if (send_out !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got %b expected 1", k, send_out); end
      checks++; if (ack_in !== 2'b00) begin failures++; $display("FAIL bp_ack[%0d] got %b expected 00", k, ack_in); end
    end
    cyc();
    ack_out = 1'b1;
    wait_idle("backpressure");
  endtask

  task automatic test_bubble();
    cyc();
    push_in(0, 32'hA0, 1'b0, 0);
    push_in(0, 32'hA1, 1'b0, 2);
    push_in(0, 32'hA2, 1'b1, 0);
    push_in(1, 32'hB0, 1'b1, 0);
    expect_out(1'b0, 32'hA0, 1'b0);
    expect_out(1'b0, 32'hA1, 1'b0);
    expect_out(1'b0, 32'hA2, 1'b1);
    expect_out(1'b1, 32'hB0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (ack_in[1] !== 1'b0) begin failures++; $display("FAIL bubble_ack1[%0d] got %b expected 0", k, ack_in[1]); end
      if (k >= 1) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bubble_busy[%0d] got %b expected 1", k, busy); end
      end
    end
    @(negedge clk);
    checks++; if (ack_in !== 2'b10) begin failures++; $display("FAIL bubble_release got %b expected 10", ack_in); end
    wait_idle("bubble");
  endtask

  task automatic test_reset_mid();
    cyc();
    ack_out = 1'b0;
    push_in(1, 32'hB0, 1'b0, 0);
    push_in(1, 32'hB1, 1'b1, 0);
    @(negedge clk);
    checks++; if (ack_in !== 2'b10) begin failures++; $display("FAIL mid_first_ack got %b expected 10", ack_in); end
    cyc();
    mr = 1'b1;
    push_in(0, 32'hA0, 1'b1, 0);
    expect_out(1'b0, 32'hA0, 1'b1);
    expect_out(1'b1, 32'hB1, 1'b1);
    @(negedge clk);
    checks++; if (ack_in !== 2'b00) begin failures++; $display("FAIL mid_ack_in_reset got %b expected 00", ack_in); end
    checks++; if (send_out !== 1'b1) begin failures++; $display("FAIL mid_held_word got %b expected 1", send_out); end
    cyc();
    mr = 1'b0;
    @(negedge clk);
    checks++; if (send_out !== 1'b0) begin failures++; $display("FAIL mid_ov_cleared got %b expected 0", send_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got %b expected 0", busy); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL mid_data_cleared got %h expected 00000000", data_out); end
    checks++; if (ack_in !== 2'b01) begin failures++; $display("FAIL mid_grant0 got %b expected 01", ack_in); end
    cyc();
    ack_out = 1'b1;
    wait_idle("reset_mid");
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    mr          = 1'b1;
    ack_out     = 1'b1;
    send_in     = '0;
    last_in     = '0;
    data_in     = '0;
    took        = '0;
    gap_left[0] = 0;
    gap_left[1] = 0;
    test_reset();
    test_fair();
    test_atomic();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
